// File: rtl/alu_seq_ctrl.sv
// ALU control decoder with an attached iterative shift-add multiplier.
// Non-MUL operations decode in a single cycle; MUL holds the pipeline for DATA_W cycles.
module alu_seq_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic [5:0]        funct_i,
   input  logic [2:0]        ALUOp_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   output logic [3:0]        ALUCtrl_o,
   output logic              illegal_o,
   output logic              stall_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] mul_result_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [3:0] CTRL_MUL = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] mcand_reg, mcand_next;
   logic [DATA_W-1:0] mplier_reg, mplier_next;
   logic [DATA_W-1:0] acc_reg, acc_next;
   logic [DATA_W-1:0] result_reg, result_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;

   logic [3:0] dec_ctrl;
   logic       dec_illegal;
   logic       dec_mul;

   // Pure decode of the incoming instruction, independent of valid_i and state
   always_comb begin
      dec_ctrl    = 4'b1111;
      dec_illegal = 1'b1;
      case (ALUOp_i)
         3'b000, 3'b100: begin dec_ctrl = 4'b0010; dec_illegal = 1'b0; end
         3'b001:         begin dec_ctrl = 4'b0110; dec_illegal = 1'b0; end
         3'b101:         begin dec_ctrl = 4'b0001; dec_illegal = 1'b0; end
         3'b010: begin
            case (funct_i)
               6'b100000: begin dec_ctrl = 4'b0010; dec_illegal = 1'b0; end
               6'b100010: begin dec_ctrl = 4'b0110; dec_illegal = 1'b0; end
               6'b100100: begin dec_ctrl = 4'b0000; dec_illegal = 1'b0; end
               6'b100101: begin dec_ctrl = 4'b0001; dec_illegal = 1'b0; end
               6'b101010: begin dec_ctrl = 4'b0111; dec_illegal = 1'b0; end
               6'b011000: begin dec_ctrl = CTRL_MUL; dec_illegal = 1'b0; end
               default:   begin dec_ctrl = 4'b1111; dec_illegal = 1'b1; end
            endcase
         end
         default:        begin dec_ctrl = 4'b1111; dec_illegal = 1'b1; end
      endcase
      dec_mul = !dec_illegal && (dec_ctrl == CTRL_MUL);
   end

   always_comb begin
      state_next  = state_reg;
      mcand_next  = mcand_reg;
      mplier_next = mplier_reg;
      acc_next    = acc_reg;
      result_next = result_reg;
      cnt_next    = cnt_reg;
      ALUCtrl_o   = dec_ctrl;
      illegal_o   = dec_illegal;
      stall_o     = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (valid_i && dec_mul) begin
               stall_o     = 1'b1;
               state_next  = ST_MUL;
               mcand_next  = src1_i;
               mplier_next = src2_i;
               acc_next    = '0;
               cnt_next    = '0;
            end
         end
         ST_MUL: begin
            ALUCtrl_o   = CTRL_MUL;
            illegal_o   = 1'b0;
            stall_o     = 1'b1;
            busy_o      = 1'b1;
            acc_next    = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg + CNT_W'(1);
            // Last partial product lands in the same edge that publishes the result
            if (cnt_reg == CNT_W'(DATA_W - 1)) begin
               state_next  = ST_DONE;
               result_next = acc_next;
            end
         end
         ST_DONE: begin
            ALUCtrl_o  = CTRL_MUL;
            illegal_o  = 1'b0;
            done_o     = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg  <= ST_IDLE;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         result_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         mcand_reg  <= mcand_next;
         mplier_reg <= mplier_next;
         acc_reg    <= acc_next;
         result_reg <= result_next;
         cnt_reg    <= cnt_next;
      end
   end

   assign mul_result_o = result_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench: a 32-bit and an 8-bit instance share control inputs and are
// compared against an arithmetic reference for decode, multiply timing and products.
module tb_alu_seq_ctrl;

   logic        clk;
   logic        rst_n_drv;
   logic        valid;
   logic [5:0]  funct;
   logic [2:0]  aluop;
   logic [31:0] src1, src2;
   logic [7:0]  src1_8, src2_8;

   logic [3:0]  ctrl32, ctrl8;
   logic        ill32, ill8, stall32, stall8, busy32, busy8, done32, done8;
   logic [31:0] res32;
   logic [7:0]  res8;

   int cmp_cnt = 0;
   int err_cnt = 0;
   logic [31:0] old32;
   logic [7:0]  old8;

   assign src1_8 = src1[7:0];
   assign src2_8 = src2[7:0];

   alu_seq_ctrl #(.DATA_W(32)) u_dut32 (
      .clk_i(clk), .rst_i(rst_n_drv), .valid_i(valid), .funct_i(funct), .ALUOp_i(aluop),
      .src1_i(src1), .src2_i(src2), .ALUCtrl_o(ctrl32), .illegal_o(ill32), .stall_o(stall32),
      .busy_o(busy32), .done_o(done32), .mul_result_o(res32)
   );

   alu_seq_ctrl #(.DATA_W(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst_n_drv), .valid_i(valid), .funct_i(funct), .ALUOp_i(aluop),
      .src1_i(src1_8), .src2_i(src2_8), .ALUCtrl_o(ctrl8), .illegal_o(ill8), .stall_o(stall8),
      .busy_o(busy8), .done_o(done8), .mul_result_o(res8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference decode: {illegal, ctrl}
   function automatic logic [4:0] ref_dec(input logic [2:0] op, input logic [5:0] fn);
      if (op == 3'd0 || op == 3'd4) return 5'h02;
      if (op == 3'd1) return 5'h06;
      if (op == 3'd5) return 5'h01;
      if (op == 3'd2) begin
         if (fn == 6'h20) return 5'h02;
         if (fn == 6'h22) return 5'h06;
         if (fn == 6'h24) return 5'h00;
         if (fn == 6'h25) return 5'h01;
         if (fn == 6'h2A) return 5'h07;
         if (fn == 6'h18) return 5'h08;
      end
      return 5'h1F;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   // Present one IDLE instruction and check decode, stall and that no state change follows
   task automatic check_decode(input logic [2:0] op, input logic [5:0] fn, input logic v);
      logic [4:0] e;
      logic       is_mul;
      e = ref_dec(op, fn);
      is_mul = (e == 5'h08);
      aluop = op; funct = fn; valid = v;
      src1 = $urandom; src2 = $urandom;
      #1;
      $display("decode op=%03b fn=%06b v=%0b -> ctrl=%04b ill=%0b stall=%0b", op, fn, v, ctrl32, ill32, stall32);
      chk("dec_ctrl32", ctrl32, e[3:0]);
      chk("dec_ill32", ill32, e[4]);
      chk("dec_ctrl8", ctrl8, e[3:0]);
      chk("dec_stall32", stall32, v & is_mul);
      chk("dec_busy32", busy32, 1'b0);
      if (!(v && is_mul)) begin
         next_cycle();
         chk("dec_no_state_busy", busy32, 1'b0);
         chk("dec_no_state_done", done32, 1'b0);
      end
   endtask

   // Issue a MUL in the current IDLE cycle and follow both instances to completion
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit add_during);
      logic [63:0] p32;
      logic [15:0] p8;
      logic [31:0] e32;
      logic [7:0]  e8;
      p32 = {32'd0, a} * {32'd0, b};
      p8  = {8'd0, a[7:0]} * {8'd0, b[7:0]};
      e32 = p32[31:0];
      e8  = p8[7:0];
      valid = 1'b1; aluop = 3'b010; funct = 6'b011000; src1 = a; src2 = b;
      #1;
      chk("acc_stall32", stall32, 1'b1);
      chk("acc_stall8", stall8, 1'b1);
      chk("acc_ctrl32", ctrl32, 4'b1000);
      for (int k = 1; k <= 33; k++) begin
         next_cycle();
         if (k == 1) begin
            valid = add_during; aluop = 3'b000; funct = 6'($urandom);
            src1 = $urandom; src2 = $urandom;
         end
         #1;
         chk("mul_busy32", busy32, k <= 32);
         chk("mul_done32", done32, k == 33);
         chk("mul_stall32", stall32, k <= 32);
         chk("mul_ctrl32", ctrl32, 4'b1000);
         chk("mul_ill32", ill32, 1'b0);
         chk("mul_res32", res32, (k == 33) ? e32 : old32);
         chk("mul_busy8", busy8, k <= 8);
         chk("mul_done8", done8, k == 9);
         chk("mul_res8", res8, (k >= 9) ? e8 : old8);
         if (k <= 9) chk("mul_ctrl8", ctrl8, 4'b1000);
      end
      $display("mul %08h x %08h add=%0b -> res32=%08h res8=%02h", a, b, add_during, res32, res8);
      next_cycle();
      valid = 1'b0; aluop = 3'b000;
      #1;
      chk("post_done32", done32, 1'b0);
      chk("post_busy32", busy32, 1'b0);
      chk("post_res32", res32, e32);
      old32 = e32;
      old8  = e8;
   endtask

   // Start a MUL and pull reset mid-operation, between clock edges
   task automatic mul_with_reset(input logic [31:0] a, input logic [31:0] b);
      valid = 1'b1; aluop = 3'b010; funct = 6'b011000; src1 = a; src2 = b;
      for (int k = 1; k <= 10; k++) begin
         next_cycle();
         valid = 1'b0;
      end
      rst_n_drv = 1'b0;
      #1;
      $display("async reset at mul cycle 10 -> busy=%0b done=%0b res32=%08h res8=%02h", busy32, done32, res32, res8);
      chk("rst_busy32", busy32, 1'b0);
      chk("rst_done32", done32, 1'b0);
      chk("rst_res32", res32, 32'd0);
      chk("rst_stall32", stall32, 1'b0);
      chk("rst_res8", res8, 8'd0);
      chk("rst_busy8", busy8, 1'b0);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         chk("rst_hold_done32", done32, 1'b0);
         chk("rst_hold_busy32", busy32, 1'b0);
      end
      rst_n_drv = 1'b1;
      old32 = '0;
      old8  = '0;
   endtask

   initial begin
      logic [2:0] op;
      logic [5:0] fn;
      logic [5:0] legal_fn [6];
      legal_fn[0] = 6'h20; legal_fn[1] = 6'h22; legal_fn[2] = 6'h24;
      legal_fn[3] = 6'h25; legal_fn[4] = 6'h2A; legal_fn[5] = 6'h18;

      rst_n_drv = 1'b0; valid = 1'b0; aluop = 3'b000; funct = '0; src1 = '0; src2 = '0;
      old32 = '0; old8 = '0;
      #1;
      chk("reset_busy32", busy32, 1'b0);
      chk("reset_done32", done32, 1'b0);
      chk("reset_res32", res32, 32'd0);
      chk("reset_res8", res8, 8'd0);
      @(posedge clk);
      #2;
      rst_n_drv = 1'b1;

      // First edge after reset release accepts a MUL
      do_mul(32'd7, 32'd6, 1'b0);
      do_mul(32'hFFFF_FFFF, 32'd2, 1'b0);
      do_mul(32'd0, 32'h1234_5678, 1'b1);
      do_mul(32'h10, 32'h10, 1'b0);

      check_decode(3'b010, 6'b100010, 1'b1);
      check_decode(3'b111, 6'b000000, 1'b1);
      check_decode(3'b010, 6'b000000, 1'b1);
      check_decode(3'b011, 6'b100000, 1'b0);
      check_decode(3'b110, 6'b011000, 1'b1);
      check_decode(3'b010, 6'b011000, 1'b0);
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 7));
         fn = ($urandom_range(0, 1) == 1) ? legal_fn[$urandom_range(0, 5)] : 6'($urandom);
         check_decode(op, fn, 1'($urandom));
      end
      valid = 1'b0;

      for (int i = 0; i < 4; i++) do_mul($urandom, $urandom, 1'($urandom));

      mul_with_reset(32'd1234, 32'd5678);
      do_mul(32'd3, 32'd5, 1'b0);
      do_mul($urandom, $urandom, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/product width (legal range 4..64).
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i  input  1  instruction presented this cycle.
REQ-005 SHALL have port funct_i  input  6  R-type function field.
REQ-006 SHALL have port ALUOp_i  input  3  main-control ALU operation class.
REQ-007 SHALL have port src1_i  input  DATA_W  multiplicand.
REQ-008 SHALL have port src2_i  input  DATA_W  multiplier.
REQ-009 SHALL have port ALUCtrl_o  output  4  ALU operation select.
REQ-010 SHALL have port illegal_o  output  1  undecodable ALUOp_i/funct_i combination.
REQ-011 SHALL have port stall_o  output  1  upstream pipeline must hold.
REQ-012 SHALL have port busy_o  output  1  iterative multiply in progress.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse, product valid.
REQ-014 SHALL have port mul_result_o  output  DATA_W  low DATA_W bits of last product.

Function
REQ-015 SHALL decode combinationally in IDLE: ALUOp 000 -> 0010; 001 -> 0110; 100 -> 0010; 101 -> 0001.
REQ-016 SHALL decode ALUOp 010 by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 011000 -> 1000 (MUL).
REQ-017 SHALL drive ALUCtrl_o = 1111 and illegal_o = 1 for ALUOp 011/110/111, or for ALUOp 010 with any other funct; illegal_o = 0 otherwise; no state change on illegal.
REQ-018 SHALL decode regardless of valid_i; valid_i only gates MUL acceptance.
REQ-019 SHALL implement FSM states IDLE, MUL, DONE.
REQ-020 IDLE -> MUL when valid_i = 1 and decode = MUL: latch src1_i, src2_i; clear accumulator; clear counter.
REQ-021 SHALL, each MUL cycle, add shifted multiplicand to the accumulator if the multiplier LSB = 1, shift multiplicand left 1, shift multiplier right 1, increment counter (width clog2(DATA_W+1)).
REQ-022 MUL -> DONE after exactly DATA_W MUL cycles; DONE -> IDLE unconditionally after one cycle.
REQ-023 SHALL compute modulo 2^DATA_W; upper product bits discarded; operands unsigned.
REQ-024 SHALL update mul_result_o on the MUL -> DONE edge and hold it until the next DONE entry.
REQ-025 done_o = 1 only in DONE; first visible DATA_W+1 cycles after the accept edge.
REQ-026 busy_o = 1 only in MUL.
REQ-027 stall_o = (state == MUL) OR (state == IDLE AND valid_i AND decode = MUL); stall_o = 0 in DONE.
REQ-028 SHALL hold ALUCtrl_o = 1000 and illegal_o = 0 in MUL and DONE; ignore valid_i, funct_i, ALUOp_i, src1_i, src2_i there.
REQ-029 SHALL accept a new MUL in IDLE on the cycle immediately after DONE (no extra gap).
REQ-030 non-MUL ops SHALL be single-cycle: no state change, stall_o = 0, done_o = 0.

Reset
REQ-031 rst_i low SHALL immediately force: state IDLE, busy_o 0, done_o 0, mul_result_o 0, accumulator/counter/operand registers 0, independent of clk_i.
REQ-032 reset mid-MUL SHALL abort the operation with no done_o pulse; mul_result_o = 0.
REQ-033 after rst_i deassertion, the first rising edge SHALL be able to accept a MUL.

Verification
REQ-034 ALUOp 010, funct 100010, valid_i 1 -> ALUCtrl_o 0110, illegal_o 0, stall_o 0, busy_o 0.
REQ-035 DATA_W 32, MUL src1 7, src2 6 -> stall_o 1 in the accept cycle; busy_o for 32 cycles; done_o pulse 33 cycles after accept; mul_result_o 42.
REQ-036 MUL 0xFFFFFFFF x 2 -> mul_result_o 0xFFFFFFFE; MUL 0 x 0x12345678 -> 0.
REQ-037 ADD (ALUOp 000) presented with valid_i during MUL -> ALUCtrl_o stays 1000, stall_o 1, product unaffected.
REQ-038 rst_i low at MUL cycle 10 -> all outputs at reset values without a clock edge; no done_o; next MUL 3 x 5 -> 15.
REQ-039 ALUOp 111, then ALUOp 010 with funct 000000 -> ALUCtrl_o 1111, illegal_o 1, state IDLE; DATA_W 8 MUL 0x10 x 0x10 -> done_o after 9 cycles, mul_result_o 0x00.
